countdown_timer: RTL and testbench

Loadable down-counter, the counting-down counterpart of the free-running up-counter used for cycle/event counting in the CPU test harness. It is loaded with a start value, decrements on enabled cycles, flags expiry with a one-cycle pulse, and optionally auto-reloads for periodic ticks. It sits beside the up-counter for timeouts, periodic display refresh and delay generation on the board.

---
 rtl/timer_pkg.sv | 11 +
 rtl/countdown_timer_prescale_tick.sv | 39 +++
 rtl/countdown_timer.sv | 89 ++++++++
 tb/tb_countdown_timer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and default count width.
package timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 16;

endpackage : timer_pkg

// File: rtl/countdown_timer_prescale_tick.sv
// Enable-cycle divider: raises tick_o on every DIV-th enabled cycle.
// Only instantiated when COUNTDOWN_PRESCALE_EN is defined.
module prescale_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : prescale_tick

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle expiry pulse and optional auto-reload.
// Define COUNTDOWN_PRESCALE_EN to decrement only every PRESCALE_DIV enabled cycles.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int PRESCALE_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             expired,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expired_q, expired_d;
    logic             tick;

`ifdef COUNTDOWN_PRESCALE_EN
    prescale_tick #(
        .DIV(PRESCALE_DIV)
    ) u_prescale (
        .clk     (clk),
        .rst     (rst),
        .clear_i (load),
        .en_i    (en && (state_q == ST_RUN)),
        .tick_o  (tick)
    );
`else
    assign tick = en;

    logic unused_prescale_div;
    assign unused_prescale_div = (PRESCALE_DIV >= 1);
`endif

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        reload_d  = reload_q;
        expired_d = 1'b0;

        if (load) begin
            out_d    = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? ST_RUN : ST_IDLE;
        end else if ((state_q == ST_RUN) && tick) begin
            // RUN always holds a nonzero count, so <=1 is the terminal value.
            if (out_q <= WIDTH'(1)) begin
                expired_d = 1'b1;
                if (auto_reload) begin
                    out_d = reload_q;
                end else begin
                    out_d   = '0;
                    state_d = ST_IDLE;
                end
            end else begin
                out_d = out_q - WIDTH'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            out_q     <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
        end
    end

    assign out     = out_q;
    assign expired = expired_q;
    assign busy    = (state_q == ST_RUN);

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: driver queues hand-computed expectations,
// a monitor pops and compares one entry after each clock edge.
module tb_countdown_timer;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] out;
        logic         expired;
        logic         busy;
    } obs_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         auto_reload;
    logic [W-1:0] out;
    logic         expired;
    logic         busy;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_compared;
    int    n_mismatched;

    countdown_timer #(
        .WIDTH        (W),
        .PRESCALE_DIV (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .out         (out),
        .expired     (expired),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input obs_t act, input obs_t req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("FAIL %s: got out=%h expired=%b busy=%b, want out=%h expired=%b busy=%b",
                     name, act.out, act.expired, act.busy, req.out, req.expired, req.busy);
        end
    endtask

    // Monitor: outputs settle just after each rising edge.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            obs_t  req;
            obs_t  act;
            string nm;
            req = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = '{out: out, expired: expired, busy: busy};
            check(nm, act, req);
        end
    end

    // Driver: apply inputs at the falling edge, queue the state expected after the next rising edge.
    task automatic drive(input logic r, input logic e, input logic l, input logic [W-1:0] lv,
                         input logic ar, input logic [W-1:0] x_out, input logic x_exp,
                         input logic x_busy, input string name);
        @(negedge clk);
        rst         = r;
        en          = e;
        load        = l;
        load_val    = lv;
        auto_reload = ar;
        exp_q.push_back('{out: x_out, expired: x_exp, busy: x_busy});
        name_q.push_back(name);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b0;
        en           = 1'b0;
        load         = 1'b0;
        load_val     = '0;
        auto_reload  = 1'b0;

        // Reset dominates a simultaneous load.
        drive(0, 0, 1, 16'h0005, 0, 16'd0, 0, 0, "rst_hold0");
        drive(0, 0, 1, 16'h0005, 0, 16'd0, 0, 0, "rst_hold1");
        drive(1, 0, 0, 16'h0000, 0, 16'd0, 0, 0, "rst_release");

`ifdef COUNTDOWN_PRESCALE_EN
        drive(1, 1, 1, 16'd2, 0, 16'd2, 0, 1, "ps_load2");
        for (int k = 1; k <= 8; k++) begin
            drive(1, 1, 0, 16'd0, 0, (k < 4) ? 16'd2 : (k < 8) ? 16'd1 : 16'd0,
                  (k == 8), (k < 8), $sformatf("ps_en_cyc%0d", k));
        end
        drive(1, 1, 1, 16'd2, 0, 16'd2, 0, 1, "ps_load2b");
        for (int k = 1; k <= 16; k++) begin
            drive(1, (k % 2 == 0), 0, 16'd0, 0, (k < 8) ? 16'd2 : (k < 16) ? 16'd1 : 16'd0,
                  (k == 16), (k < 16), $sformatf("ps_half_cyc%0d", k));
        end
`else
        // One-shot from 3.
        drive(1, 1, 1, 16'd3, 0, 16'd3, 0, 1, "os_load3");
        drive(1, 1, 0, 16'd0, 0, 16'd2, 0, 1, "os_2");
        drive(1, 1, 0, 16'd0, 0, 16'd1, 0, 1, "os_1");
        drive(1, 1, 0, 16'd0, 0, 16'd0, 1, 0, "os_expire");
        for (int k = 0; k < 10; k++) begin
            drive(1, 1, 0, 16'd0, 0, 16'd0, 0, 0, $sformatf("os_hold0_%0d", k));
        end

        // Auto-reload from 2: pulse every second tick.
        drive(1, 1, 1, 16'd2, 1, 16'd2, 0, 1, "ar_load2");
        for (int k = 1; k <= 8; k++) begin
            drive(1, 1, 0, 16'd0, 1, (k % 2 == 1) ? 16'd1 : 16'd2, (k % 2 == 0), 1,
                  $sformatf("ar2_cyc%0d", k));
        end

        // Auto-reload from 1: expired stays high.
        drive(1, 1, 1, 16'd1, 1, 16'd1, 0, 1, "ar_load1");
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1, 0, 16'd0, 1, 16'd1, 1, 1, $sformatf("ar1_cyc%0d", k));
        end

        // Enable gating, then load colliding with the terminal tick.
        drive(1, 1, 1, 16'd4, 0, 16'd4, 0, 1, "en_load4");
        drive(1, 1, 0, 16'd0, 0, 16'd3, 0, 1, "en_on_3");
        drive(1, 0, 0, 16'd0, 0, 16'd3, 0, 1, "en_off_3");
        drive(1, 1, 0, 16'd0, 0, 16'd2, 0, 1, "en_on_2");
        drive(1, 0, 0, 16'd0, 0, 16'd2, 0, 1, "en_off_2");
        drive(1, 1, 0, 16'd0, 0, 16'd1, 0, 1, "en_on_1");
        drive(1, 1, 1, 16'h00FF, 0, 16'h00FF, 0, 1, "load_vs_terminal");
        drive(1, 0, 0, 16'd0, 0, 16'h00FF, 0, 1, "load_ff_hold");

        // Zero load never runs or pulses.
        drive(1, 1, 1, 16'd0, 0, 16'd0, 0, 0, "zero_load");
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 16'd0, 0, 16'd0, 0, 0, $sformatf("zero_idle_%0d", k));
        end

        // Reset in the middle of a count.
        drive(1, 1, 1, 16'd9, 0, 16'd9, 0, 1, "mid_load9");
        drive(1, 1, 0, 16'd0, 0, 16'd8, 0, 1, "mid_8");
        drive(1, 1, 0, 16'd0, 0, 16'd7, 0, 1, "mid_7");
        drive(1, 1, 0, 16'd0, 0, 16'd6, 0, 1, "mid_6");
        drive(0, 1, 0, 16'd0, 0, 16'd0, 0, 0, "mid_rst");
        drive(1, 1, 0, 16'd0, 0, 16'd0, 0, 0, "mid_after_rst");
`endif

        // Let the monitor drain, bounded.
        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                #3;
                budget--;
            end
            if (exp_q.size() > 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_countdown_timer
